// File: rtl/pc_unit.sv
// Program-counter unit for the rv32i fetch stage: issues fetch addresses over a
// valid/ready handshake and handles redirects, trap entry and misaligned targets.
module pc_unit #(
  parameter int unsigned        XLEN       = 32,
  parameter logic [XLEN-1:0]    RESET_ADDR = {XLEN{1'b0}},
  parameter int unsigned        INC        = 4,
  parameter int unsigned        IALIGN     = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic            misaligned_o,
  output logic [XLEN-1:0] misaligned_addr_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic            mis_q;
  logic [XLEN-1:0] mis_addr_q;

  logic            redir_bad;
  logic [XLEN-1:0] trap_pc;
  logic            accept;

  // Masking (rather than slicing) keeps every trap_vec_i bit in the expression.
  assign trap_pc   = trap_vec_i & ~XLEN'(3);
  assign redir_bad = (IALIGN == 16) ? redirect_addr_i[0] : (|redirect_addr_i[1:0]);
  assign accept    = valid_q & fetch_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_ADDR;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      mis_q <= 1'b0;
      if (trap_i) begin
        state_q <= RUN;
        pc_q    <= trap_pc;
        valid_q <= 1'b1;
      end else begin
        case (state_q)
          BOOT, RUN: begin
            if (redirect_valid_i && redir_bad) begin
              state_q    <= FAULT;
              valid_q    <= 1'b0;
              mis_q      <= 1'b1;
              mis_addr_q <= redirect_addr_i;
            end else if (redirect_valid_i) begin
              state_q <= RUN;
              pc_q    <= redirect_addr_i;
              valid_q <= 1'b1;
            end else if (state_q == BOOT) begin
              state_q <= RUN;
              valid_q <= 1'b1;
            end else if (accept) begin
              pc_q <= pc_q + XLEN'(INC);
            end
          end
          FAULT: begin
            valid_q <= 1'b0;
          end
          default: begin
            state_q <= BOOT;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fetch_valid_o     = valid_q;
  assign pc_o              = pc_q;
  assign misaligned_o      = mis_q;
  assign misaligned_addr_o = mis_addr_q;
  assign state_o           = state_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the rv32i fetch stage. It generates the instruction fetch address and offers it to the instruction-memory port through a valid/ready handshake. The PC advances only on an accepted fetch. It supports branch/jump redirects and trap-vector entry, and detects misaligned redirect targets, entering a fault state until a trap is taken.

Parameters:
XLEN, 32, address width in bits.
RESET_ADDR, {XLEN{1'b0}}, PC value loaded on reset.
INC, 4, increment applied on each accepted fetch. Must be a multiple of IALIGN/8.
IALIGN, 32, instruction alignment in bits (32 or 16). Selects the misalignment check.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_ni  input  1  synchronous reset, active-low; sampled on rising edge of clk_i.
fetch_valid_o  output  1  pc_o holds a fetch address ready for issue.
fetch_ready_i  input  1  fetch port accepts pc_o this cycle.
pc_o  output  XLEN  current fetch address.
redirect_valid_i  input  1  branch/jump taken; load redirect_addr_i.
redirect_addr_i  input  XLEN  redirect target.
trap_i  input  1  trap entry request.
trap_vec_i  input  XLEN  trap handler base; low 2 bits ignored.
misaligned_o  output  1  one-cycle pulse on a rejected misaligned redirect.
misaligned_addr_o  output  XLEN  offending target, held until the next misaligned event or reset.
state_o  output  2  debug: 0 BOOT, 1 RUN, 2 FAULT.

Behaviour:
- Reset: rst_ni low at a posedge sets pc_o=RESET_ADDR, fetch_valid_o=0, misaligned_o=0, misaligned_addr_o=0, state BOOT. Reset overrides every other input. Reset asserted mid-operation discards any pending redirect or trap.
- BOOT: lasts exactly one cycle after reset deasserts, with fetch_valid_o=0, then moves to RUN.
  - A redirect or trap presented in BOOT is honoured: pc_o takes the target and the state moves to RUN.
- RUN: fetch_valid_o=1.
  - Accept = fetch_valid_o & fetch_ready_i.
  - On accept with no redirect or trap: pc_o <= pc_o + INC, modulo 2^XLEN. 0xFFFF_FFFC+4 wraps to 0x0000_0000.
  - Without accept: pc_o holds. fetch_valid_o never drops while in RUN without a redirect or trap.
- Priority within a cycle: reset > trap_i > redirect_valid_i > accept-increment > hold.
- Redirect (RUN or BOOT), target aligned:
  - pc_o <= redirect_addr_i on the next cycle, whether or not the current address was accepted. The unaccepted address is dropped.
  - Latency is 1 cycle; fetch_valid_o stays 1.
- Misaligned redirect:
  - Misaligned means redirect_addr_i[1:0]!=0 when IALIGN=32, or redirect_addr_i[0]!=0 when IALIGN=16.
  - pc_o is not updated. misaligned_o=1 for exactly the next cycle and misaligned_addr_o<=redirect_addr_i.
  - State moves to FAULT and fetch_valid_o=0 from the next cycle.
- FAULT: fetch_valid_o=0, pc_o holds, and redirects are ignored. Only trap_i or reset leaves FAULT.
- Trap (any state except reset):
  - pc_o <= {trap_vec_i[XLEN-1:2],2'b00} and state moves to RUN next cycle, with fetch_valid_o=1.
  - A trap concurrent with a misaligned redirect takes the trap; no misaligned pulse is generated.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset with RESET_ADDR=0x100: rst_ni=0 for 2 cycles, then 1, with fetch_ready_i=1 throughout -> cycle 1 after release: valid=0, pc=0x100. Following cycles: pc=0x100, 0x104, 0x108, with valid=1.
- Backpressure: in RUN at pc=0x200, fetch_ready_i=0 for 3 cycles then 1 -> pc holds 0x200 with valid=1 for 3 cycles, then advances to 0x204.
- Redirect: at pc=0x300 with fetch_ready_i=0, redirect to 0x1000 -> next cycle pc=0x1000, valid=1. Accept then gives 0x1004. Wrap check: redirect to 0xFFFFFFFC plus accept -> 0x00000000.
- Misaligned: redirect to 0x1002 with IALIGN=32 -> pc unchanged, misaligned_o=1 for one cycle, misaligned_addr_o=0x1002, valid=0. A subsequent redirect to 0x2000 is ignored. trap_i with trap_vec_i=0x80000003 -> pc=0x80000000, valid=1, state RUN.
- Priority: trap_i, redirect_valid_i and accept all in the same cycle -> pc=trap vector. With IALIGN=16, a redirect to 0x1002 is accepted as aligned.
- Mid-operation reset: rst_ni=0 while in FAULT with a trap pending -> pc=RESET_ADDR, state BOOT, misaligned_addr_o=0, and no trap effect.
